// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and report its sign.
module bin2bcd_seq #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf,
    output logic                sign
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [BCD_W-1:0] work, work_next;
    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] bcd_next;
    logic [WIDTH-1:0] operand;
    logic             ovf_sticky, sticky_next;
    logic             busy_next, done_next, ovf_next;
    logic             carry;

    // Digits >= 5 would reach >= 10 after doubling; pre-add 3 so the shift carries out.
    function automatic logic [3:0] adjust_digit(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

`ifdef BIN2BCD_SIGNED_EN
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    assign operand = magnitude(bin);
`else
    assign operand = bin;
`endif

    always_comb begin
        adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            adj[4*k +: 4] = adjust_digit(work[4*k +: 4]);
        end
    end

    assign carry = adj[BCD_W-1];

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        shreg_next  = shreg;
        work_next   = work;
        sticky_next = ovf_sticky;
        busy_next   = 1'b0;
        done_next   = 1'b0;
        bcd_next    = bcd;
        ovf_next    = ovf;
        case (state)
            IDLE: begin
                if (start) begin
                    shreg_next  = operand;
                    work_next   = '0;
                    sticky_next = 1'b0;
                    cnt_next    = CNT_W'(WIDTH - 1);
                    state_next  = SHIFT;
                    busy_next   = 1'b1;
                end
            end
            SHIFT: begin
                work_next   = {adj[BCD_W-2:0], shreg[WIDTH-1]};
                shreg_next  = {shreg[WIDTH-2:0], 1'b0};
                sticky_next = ovf_sticky | carry;
                if (cnt == '0) begin
                    bcd_next   = work_next;
                    ovf_next   = ovf_sticky | carry;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next  = cnt - 1'b1;
                    busy_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            work       <= '0;
            ovf_sticky <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd        <= '0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            shreg      <= shreg_next;
            work       <= work_next;
            ovf_sticky <= sticky_next;
            busy       <= busy_next;
            done       <= done_next;
            bcd        <= bcd_next;
            ovf        <= ovf_next;
        end
    end

`ifdef BIN2BCD_SIGNED_EN
    logic sign_pend, sign_q;

    // Sign is captured at acceptance but only published alongside the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_pend <= 1'b0;
            sign_q    <= 1'b0;
        end else begin
            if (state == IDLE && start) sign_pend <= bin[WIDTH-1];
            if (state == SHIFT && cnt == '0) sign_q <= sign_pend;
        end
    end

    assign sign = sign_q;
`else
    assign sign = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: scoreboard of expected results plus timing checks.
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] bin = '0;
    logic        busy, done, ovf, sign;
    logic [15:0] bcd;

    logic        start3 = 1'b0;
    logic [11:0] bin3 = '0;
    logic        busy3, done3, ovf3, sign3;
    logic [11:0] bcd3;

    int total = 0;
    int bad   = 0;

    logic [17:0] exp_q[$];
    logic [17:0] exp3_q[$];
    logic [17:0] e0, e3;

    bin2bcd_seq #(.WIDTH(12), .DIGITS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .sign(sign)
    );

    bin2bcd_seq #(.WIDTH(12), .DIGITS(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .bin(bin3),
        .busy(busy3), .done(done3), .bcd(bcd3), .ovf(ovf3), .sign(sign3)
    );

    always #5 clk = ~clk;

    // Reference: {sign, ovf, bcd16} computed arithmetically.
    function automatic logic [17:0] model(input logic [11:0] v, input int nd);
        int mag;
        int p;
        int lim;
        logic s;
        logic o;
        logic [15:0] b;
        s   = 1'b0;
        mag = int'(v);
`ifdef BIN2BCD_SIGNED_EN
        if (v[11]) begin
            s   = 1'b1;
            mag = 4096 - int'(v);
        end
`endif
        lim = 1;
        for (int k = 0; k < nd; k++) lim = lim * 10;
        o = (mag >= lim);
        b = '0;
        p = 1;
        for (int k = 0; k < nd; k++) begin
            b[4*k +: 4] = 4'((mag / p) % 10);
            p = p * 10;
        end
        return {s, o, b};
    endfunction

    always @(negedge clk) begin
        if (done) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_done got bcd=%h ovf=%b sign=%b required no done", bcd, ovf, sign);
            end else begin
                e0 = exp_q.pop_front();
                if ({sign, ovf, bcd} !== e0) begin
                    bad++;
                    $display("FAIL sb_result got sign/ovf/bcd=%b/%b/%h required %b/%b/%h",
                             sign, ovf, bcd, e0[17], e0[16], e0[15:0]);
                end
            end
        end
        if (done3) begin
            total++;
            if (exp3_q.size() == 0) begin
                bad++;
                $display("FAIL sb3_unexpected_done got bcd=%h ovf=%b required no done", bcd3, ovf3);
            end else begin
                e3 = exp3_q.pop_front();
                if ({sign3, ovf3, bcd3} !== {e3[17], e3[16], e3[11:0]}) begin
                    bad++;
                    $display("FAIL sb3_result got sign/ovf/bcd=%b/%b/%h required %b/%b/%h",
                             sign3, ovf3, bcd3, e3[17], e3[16], e3[11:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input logic [11:0] v);
        start = 1'b1;
        bin   = v;
        exp_q.push_back(model(v, 4));
        tick();
        start = 1'b0;
        bin   = $urandom_range(0, 4095);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wait_done timeout got done=%b required 1 within %0d cycles", done, budget);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if ({busy, done, bcd, ovf, sign} !== 20'h0) begin
            bad++;
            $display("FAIL reset_state got busy/done/bcd/ovf/sign=%b/%b/%h/%b/%b required all 0",
                     busy, done, bcd, ovf, sign);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        start_conv(12'd4095);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL latency_busy_e0 got %b required 1", busy);
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            total++;
            if (done !== (i == 12) || busy !== (i != 12)) begin
                bad++;
                $display("FAIL latency_cycle%0d got done=%b busy=%b required done=%b busy=%b",
                         i, done, busy, (i == 12), (i != 12));
            end
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle got %b required 0", done);
        end
    endtask

    task automatic test_small_values();
        start_conv(12'd0);
        wait_done(20);
        start_conv(12'd9);
        wait_done(20);
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (bcd !== 16'h0009 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL hold_between got bcd=%h done=%b busy=%b required 0009/0/0", bcd, done, busy);
        end
        start_conv(12'd10);
        wait_done(20);
        tick();
    endtask

    task automatic test_overflow();
        logic [11:0] vals[2];
        vals[0] = 12'd1000;
        vals[1] = 12'd999;
        for (int t = 0; t < 2; t++) begin
            int n = 0;
            start3 = 1'b1;
            bin3   = vals[t];
            exp3_q.push_back(model(vals[t], 3));
            tick();
            start3 = 1'b0;
            while (!done3 && n < 20) begin
                tick();
                n++;
            end
            total++;
            if (!done3) begin
                bad++;
                $display("FAIL ovf_timeout got done3=%b required 1", done3);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        for (int c = 0; c < 39; c++) begin
            bin = $urandom_range(0, 4095);
            if (c % 13 == 0) exp_q.push_back(model(bin, 4));
            total++;
            if (busy !== (c % 13 != 0)) begin
                bad++;
                $display("FAIL b2b_accept_c%0d got busy=%b required %b", c, busy, (c % 13 != 0));
            end
            tick();
        end
        start = 1'b0;
        wait_done(20);
        tick();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        start_conv(12'd4095);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        total++;
        if ({busy, done, bcd, ovf, sign} !== 20'h0) begin
            bad++;
            $display("FAIL reset_mid got busy/done/bcd/ovf/sign=%b/%b/%h/%b/%b required all 0",
                     busy, done, bcd, ovf, sign);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) seen++;
        end
        total++;
        if (seen != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_done got %0d done pulses busy=%b required 0/0", seen, busy);
        end
        start_conv(12'd123);
        wait_done(20);
        tick();
    endtask

    task automatic test_edge_values();
        start_conv(12'h800);
        wait_done(20);
        start_conv(12'hFFF);
        wait_done(20);
        start_conv(12'd2047);
        wait_done(20);
        start_conv(12'd1);
        wait_done(20);
        tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_small_values();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_edge_values();
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (exp_q.size() != 0 || exp3_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got %0d/%0d pending required 0/0", exp_q.size(), exp3_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
